beta_rf_wr_arbiter: RTL and testbench

BETA_RF_WR_ARBITER -- requirements
Module: beta_rf_wr_arbiter

---
 rtl/beta_rf_wr_arbiter.sv | 113 +++++++++++
 tb/tb_beta_rf_wr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_rf_wr_arbiter.sv
// Arbitrates the EXE and LSU register-file write requesters onto one registered write port.
// Optional macro BETA_RF_WR_RR_EN: round-robin on contested grants (default: fixed LSU-over-EXE).
module beta_rf_wr_arbiter #(
  parameter int DataWidth = 32,
  parameter bit Embedded  = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 exe_wr_valid_i,
  output logic                 exe_wr_ready_o,
  input  logic [4:0]           exe_wr_addr_i,
  input  logic [DataWidth-1:0] exe_wr_data_i,
  input  logic                 lsu_wr_valid_i,
  output logic                 lsu_wr_ready_o,
  input  logic [4:0]           lsu_wr_addr_i,
  input  logic [DataWidth-1:0] lsu_wr_data_i,
  output logic                 rf_wr_en_o,
  output logic [4:0]           rf_rd_addr_o,
  output logic [DataWidth-1:0] rf_rd_wdata_o,
  output logic                 illegal_wr_o,
  output logic                 arb_busy_o
);

  logic                 exe_gnt;
  logic                 lsu_gnt;
  logic                 xfer;
  logic                 out_of_profile;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;

  logic                 wr_en_d, wr_en_q;
  logic                 illegal_d, illegal_q;
  logic [4:0]           addr_d, addr_q;
  logic [DataWidth-1:0] data_d, data_q;

`ifdef BETA_RF_WR_RR_EN
  typedef enum logic {LAST_EXE, LAST_LSU} last_grant_e;
  last_grant_e last_grant_d, last_grant_q;

  // Contested cycles go to whoever did not win the most recent transfer.
  always_comb begin
    exe_gnt      = 1'b0;
    lsu_gnt      = 1'b0;
    last_grant_d = last_grant_q;
    if (rstn_i) begin
      if (exe_wr_valid_i && lsu_wr_valid_i) begin
        exe_gnt = (last_grant_q == LAST_LSU);
        lsu_gnt = (last_grant_q == LAST_EXE);
      end else begin
        exe_gnt = exe_wr_valid_i;
        lsu_gnt = lsu_wr_valid_i;
      end
    end
    if (lsu_gnt) begin
      last_grant_d = LAST_LSU;
    end else if (exe_gnt) begin
      last_grant_d = LAST_EXE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_grant_q <= LAST_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    exe_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (rstn_i) begin
      lsu_gnt = lsu_wr_valid_i;
      exe_gnt = exe_wr_valid_i && !lsu_wr_valid_i;
    end
  end
`endif

  // Address/data capture on every accepted transfer, even one whose write is suppressed.
  always_comb begin
    xfer           = exe_gnt || lsu_gnt;
    sel_addr       = lsu_gnt ? lsu_wr_addr_i : exe_wr_addr_i;
    sel_data       = lsu_gnt ? lsu_wr_data_i : exe_wr_data_i;
    out_of_profile = Embedded && sel_addr[4];
    wr_en_d        = xfer && (sel_addr != 5'd0) && !out_of_profile;
    illegal_d      = xfer && out_of_profile;
    addr_d         = xfer ? sel_addr : addr_q;
    data_d         = xfer ? sel_data : data_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      illegal_q <= illegal_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign exe_wr_ready_o = exe_gnt;
  assign lsu_wr_ready_o = lsu_gnt;
  assign rf_wr_en_o     = wr_en_q;
  assign rf_rd_addr_o   = addr_q;
  assign rf_rd_wdata_o  = data_q;
  assign illegal_wr_o   = illegal_q;
  assign arb_busy_o     = exe_wr_valid_i || lsu_wr_valid_i || wr_en_q;

endmodule

// File: tb/tb_beta_rf_wr_arbiter.sv
// Bench for beta_rf_wr_arbiter: full and RV32E instances share stimulus and are checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_beta_rf_wr_arbiter;

`ifdef BETA_RF_WR_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        exe_valid, lsu_valid;
  logic [4:0]  exe_addr, lsu_addr;
  logic [31:0] exe_data, lsu_data;

  logic        exe_rdy0, lsu_rdy0, en0, ill0, busy0;
  logic [4:0]  addr0;
  logic [31:0] data0;
  logic        exe_rdy1, lsu_rdy1, en1, ill1, busy1;
  logic [4:0]  addr1;
  logic [31:0] data1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  beta_rf_wr_arbiter #(.DataWidth(32), .Embedded(1'b0)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .exe_wr_valid_i(exe_valid), .exe_wr_ready_o(exe_rdy0),
    .exe_wr_addr_i(exe_addr), .exe_wr_data_i(exe_data),
    .lsu_wr_valid_i(lsu_valid), .lsu_wr_ready_o(lsu_rdy0),
    .lsu_wr_addr_i(lsu_addr), .lsu_wr_data_i(lsu_data),
    .rf_wr_en_o(en0), .rf_rd_addr_o(addr0), .rf_rd_wdata_o(data0),
    .illegal_wr_o(ill0), .arb_busy_o(busy0)
  );

  beta_rf_wr_arbiter #(.DataWidth(32), .Embedded(1'b1)) dut_e (
    .clk_i(clk), .rstn_i(rstn),
    .exe_wr_valid_i(exe_valid), .exe_wr_ready_o(exe_rdy1),
    .exe_wr_addr_i(exe_addr), .exe_wr_data_i(exe_data),
    .lsu_wr_valid_i(lsu_valid), .lsu_wr_ready_o(lsu_rdy1),
    .lsu_wr_addr_i(lsu_addr), .lsu_wr_data_i(lsu_data),
    .rf_wr_en_o(en1), .rf_rd_addr_o(addr1), .rf_rd_wdata_o(data1),
    .illegal_wr_o(ill1), .arb_busy_o(busy1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {lsu_granted, exe_granted}.
  function automatic logic [1:0] model_grant(input logic rst_ok, input logic ev, input logic lv,
                                             input logic last_was_lsu);
    if (!rst_ok) return 2'b00;
    if (ev && lv) begin
      if (RR) return last_was_lsu ? 2'b01 : 2'b10;
      return 2'b10;
    end
    return {lv, ev};
  endfunction

  // Transaction model: what the write port must show one cycle after each accepted request.
  logic        m_last_lsu;
  logic        m_en0, m_en1, m_ill1;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_g;
  logic [4:0]  m_a;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_last_lsu = 1'b1;
      m_en0 = 1'b0; m_en1 = 1'b0; m_ill1 = 1'b0;
      m_addr = 5'd0; m_data = 32'd0;
    end else begin
      m_g = model_grant(1'b1, exe_valid, lsu_valid, m_last_lsu);
      m_en0 = 1'b0; m_en1 = 1'b0; m_ill1 = 1'b0;
      if (m_g != 2'b00) begin
        m_a    = m_g[1] ? lsu_addr : exe_addr;
        m_addr = m_a;
        m_data = m_g[1] ? lsu_data : exe_data;
        m_en0  = (m_a != 5'd0);
        m_en1  = (m_a != 5'd0) && (m_a < 5'd16);
        m_ill1 = (m_a >= 5'd16);
        m_last_lsu = m_g[1];
      end
    end
  end

  logic [1:0] c_g;
  always @(negedge clk) begin
    c_g = model_grant(rstn, exe_valid, lsu_valid, m_last_lsu);
    checkOutput("exe_rdy",    {31'd0, exe_rdy0}, {31'd0, c_g[0]});
    checkOutput("lsu_rdy",    {31'd0, lsu_rdy0}, {31'd0, c_g[1]});
    checkOutput("wr_en",      {31'd0, en0},      {31'd0, m_en0});
    checkOutput("wr_addr",    {27'd0, addr0},    {27'd0, m_addr});
    checkOutput("wr_data",    data0,             m_data);
    checkOutput("illegal",    {31'd0, ill0},     32'd0);
    checkOutput("busy",       {31'd0, busy0},    {31'd0, exe_valid | lsu_valid | m_en0});
    checkOutput("e_exe_rdy",  {31'd0, exe_rdy1}, {31'd0, c_g[0]});
    checkOutput("e_lsu_rdy",  {31'd0, lsu_rdy1}, {31'd0, c_g[1]});
    checkOutput("e_wr_en",    {31'd0, en1},      {31'd0, m_en1});
    checkOutput("e_wr_addr",  {27'd0, addr1},    {27'd0, m_addr});
    checkOutput("e_wr_data",  data1,             m_data);
    checkOutput("e_illegal",  {31'd0, ill1},     {31'd0, m_ill1});
    checkOutput("e_busy",     {31'd0, busy1},    {31'd0, exe_valid | lsu_valid | m_en1});
  end

  task automatic applyStimulus(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                               input logic lv, input logic [4:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    exe_valid = ev; exe_addr = ea; exe_data = ed;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    exe_valid = 1'b0; lsu_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  logic        s_ev, s_lv, s_exe_won, s_lsu_won;
  logic [4:0]  s_ea, s_la;
  logic [31:0] s_ed, s_ld;
  logic [1:0]  s_g;

  initial begin
    rstn = 1'b0;
    exe_valid = 1'b0; exe_addr = 5'd0; exe_data = 32'd0;
    lsu_valid = 1'b0; lsu_addr = 5'd0; lsu_data = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_en",      {31'd0, en0},      32'd0);
    checkOutput("rst_addr",    {27'd0, addr0},    32'd0);
    checkOutput("rst_data",    data0,             32'd0);
    exe_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    checkOutput("rst_exe_rdy", {31'd0, exe_rdy0}, 32'd0);
    checkOutput("rst_lsu_rdy", {31'd0, lsu_rdy0}, 32'd0);
    exe_valid = 1'b0; lsu_valid = 1'b0;
    #2;
    rstn = 1'b1;

    // Single EXE write lands one cycle later, then the port goes quiet.
    doReset();
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("d31_exe_rdy", {31'd0, exe_rdy0}, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("d31_en",      {31'd0, en0},   32'd1);
    checkOutput("d31_addr",    {27'd0, addr0}, 32'd5);
    checkOutput("d31_data",    data0,          32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("d31_en_off",  {31'd0, en0},   32'd0);
    checkOutput("d31_hold",    data0,          32'hDEADBEEF);

    // Both requesters valid continuously.
    doReset();
`ifdef BETA_RF_WR_RR_EN
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      #1;
      checkOutput("d32_exe_rdy", {31'd0, exe_rdy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("d32_lsu_rdy", {31'd0, lsu_rdy0}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) begin
        checkOutput("d32_en",   {31'd0, en0},   32'd1);
        checkOutput("d32_addr", {27'd0, addr0}, (i % 2 == 1) ? 32'd1 : 32'd2);
      end
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("d32_en_last",   {31'd0, en0},   32'd1);
    checkOutput("d32_addr_last", {27'd0, addr0}, 32'd2);
`else
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      #1;
      checkOutput("d33_lsu_rdy", {31'd0, lsu_rdy0}, 32'd1);
      checkOutput("d33_exe_rdy", {31'd0, exe_rdy0}, 32'd0);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`endif

    // Write to x0 is accepted but suppressed.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    #1;
    checkOutput("d34_lsu_rdy", {31'd0, lsu_rdy0}, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("d34_en",      {31'd0, en0},  32'd0);
    checkOutput("d34_ill",     {31'd0, ill0}, 32'd0);
    checkOutput("d34_e_ill",   {31'd0, ill1}, 32'd0);

    // x17 is out of profile for RV32E only.
    applyStimulus(1'b1, 5'd17, 32'hCAFE, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("d35_e_rdy",   {31'd0, exe_rdy1}, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("d35_e_en",    {31'd0, en1},  32'd0);
    checkOutput("d35_e_ill",   {31'd0, ill1}, 32'd1);
    checkOutput("d35_en",      {31'd0, en0},  32'd1);
    checkOutput("d35_ill",     {31'd0, ill0}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("d35_e_ill_1", {31'd0, ill1}, 32'd0);

    // Reset between handshake and the capturing edge discards the write.
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("d36_exe_rdy", {31'd0, exe_rdy0}, 32'd1);
    #1;
    rstn = 1'b0;
    exe_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("d36_en",   {31'd0, en0},   32'd0);
      checkOutput("d36_addr", {27'd0, addr0}, 32'd0);
      checkOutput("d36_data", data0,          32'd0);
      checkOutput("d36_ill",  {31'd0, ill1},  32'd0);
      checkOutput("d36_busy", {31'd0, busy0}, 32'd0);
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("d36_en_post", {31'd0, en0}, 32'd0);

    // Random traffic; a requester keeps its request until the model says it was accepted.
    s_ev = 1'b0; s_lv = 1'b0; s_exe_won = 1'b0; s_lsu_won = 1'b0;
    s_ea = 5'd0; s_la = 5'd0; s_ed = 32'd0; s_ld = 32'd0;
    for (int i = 0; i < 600; i++) begin
      if (!s_ev || s_exe_won) begin
        s_ev = ($urandom_range(0, 9) < 7);
        s_ea = 5'($urandom_range(0, 31));
        s_ed = $urandom;
      end
      if (!s_lv || s_lsu_won) begin
        s_lv = ($urandom_range(0, 9) < 6);
        s_la = 5'($urandom_range(0, 31));
        s_ld = $urandom;
      end
      applyStimulus(s_ev, s_ea, s_ed, s_lv, s_la, s_ld);
      #1;
      s_g = model_grant(rstn, exe_valid, lsu_valid, m_last_lsu);
      s_exe_won = s_g[0];
      s_lsu_won = s_g[1];
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
